sprite_attr_bank: RTL and testbench

// Parametrised bank of per-sprite attribute registers (width, height, animation step count) for the

---
 rtl/sprite_mem_pkg.sv | 15 +
 rtl/sprite_anim_counter.sv | 44 ++++
 rtl/sprite_attr_bank.sv | 133 +++++++++++++
 tb/tb_sprite_attr_bank.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/sprite_mem_pkg.sv
// Shared SpriteMem definitions: default field widths and the attribute record
// consumed by the sprite renderer.
package sprite_mem_pkg;

  localparam int unsigned DefNumSprites = 8;
  localparam int unsigned DefDimW       = 6;
  localparam int unsigned DefAnimW      = 3;

  typedef struct packed {
    logic [DefDimW-1:0]  width;
    logic [DefDimW-1:0]  height;
    logic [DefAnimW-1:0] anim_steps;
  } sprite_attr_t;

endpackage

// File: rtl/sprite_anim_counter.sv
// Per-slot animation frame counter: wraps at steps-1 on each tick, and is held
// at zero for static sprites (steps of 0 or 1).
module sprite_anim_counter
  import sprite_mem_pkg::*;
#(
  parameter int unsigned ANIM_W = DefAnimW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              tick,
  input  logic [ANIM_W-1:0] steps,
  output logic [ANIM_W-1:0] frame
);

  logic [ANIM_W-1:0] frame_q, frame_d;

  // A slot write clears the frame even on a tick edge.
  always_comb begin
    frame_d = frame_q;
    if (clear) begin
      frame_d = '0;
    end else if (tick) begin
      if (steps <= ANIM_W'(1)) begin
        frame_d = '0;
      end else if (frame_q == steps - ANIM_W'(1)) begin
        frame_d = '0;
      end else begin
        frame_d = frame_q + ANIM_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_q <= '0;
    end else begin
      frame_q <= frame_d;
    end
  end

  assign frame = frame_q;

endmodule

// File: rtl/sprite_attr_bank.sv
// Bank of per-sprite attribute registers with a write port, a 1-cycle indexed
// read port (zeroed when not valid) and a frame counter per slot.
module sprite_attr_bank
  import sprite_mem_pkg::*;
#(
  parameter int unsigned NUM_SPRITES = DefNumSprites,
  parameter int unsigned DIM_W       = DefDimW,
  parameter int unsigned ANIM_W      = DefAnimW,
  parameter int unsigned IDX_W       = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DIM_W-1:0]  wr_width,
  input  logic [DIM_W-1:0]  wr_height,
  input  logic [ANIM_W-1:0] wr_anim_steps,
  input  logic              rd_req,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic              oe,
  input  logic              frame_tick,
  output logic              rd_valid,
  output logic              rd_err,
  output logic [DIM_W-1:0]  out_width,
  output logic [DIM_W-1:0]  out_height,
  output logic [ANIM_W-1:0] out_anim_steps,
  output logic [ANIM_W-1:0] out_anim_frame
);

  typedef struct packed {
    logic [DIM_W-1:0]  width;
    logic [DIM_W-1:0]  height;
    logic [ANIM_W-1:0] anim_steps;
  } attr_t;

  // One extra bit so NUM_SPRITES itself is representable for range checks.
  localparam logic [IDX_W:0] NumSlots = (IDX_W + 1)'(NUM_SPRITES);

  attr_t             attr_q [NUM_SPRITES];
  logic [ANIM_W-1:0] frame  [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] wr_sel;

  attr_t wr_attr;
  logic  wr_hit;

  assign wr_attr = '{width: wr_width, height: wr_height, anim_steps: wr_anim_steps};
  assign wr_hit  = wr_en && ({1'b0, wr_idx} < NumSlots);

  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_slot
    assign wr_sel[i] = wr_hit && (wr_idx == IDX_W'(i));

    always_ff @(posedge clk) begin
      if (reset) begin
        attr_q[i] <= '0;
      end else if (wr_sel[i]) begin
        attr_q[i] <= wr_attr;
      end
    end

    sprite_anim_counter #(
      .ANIM_W(ANIM_W)
    ) u_anim (
      .clk   (clk),
      .reset (reset),
      .clear (wr_sel[i]),
      .tick  (frame_tick),
      .steps (attr_q[i].anim_steps),
      .frame (frame[i])
    );
  end

  attr_t             rd_attr;
  logic [ANIM_W-1:0] rd_frame;
  logic              rd_fire, rd_in_range;

  assign rd_fire     = rd_req && oe;
  assign rd_in_range = {1'b0, rd_idx} < NumSlots;

  // Read mux; a same-edge write to the addressed slot is forwarded (frame 0).
  always_comb begin
    rd_attr  = '0;
    rd_frame = '0;
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rd_attr  = attr_q[i];
        rd_frame = frame[i];
      end
    end
    if (wr_hit && (wr_idx == rd_idx)) begin
      rd_attr  = wr_attr;
      rd_frame = '0;
    end
  end

  logic              rd_valid_q, rd_valid_d;
  logic              rd_err_q, rd_err_d;
  attr_t             out_attr_q, out_attr_d;
  logic [ANIM_W-1:0] out_frame_q, out_frame_d;

  // Zero-gated data lets several banks share a wired-OR read bus.
  always_comb begin
    rd_valid_d  = rd_fire;
    rd_err_d    = rd_fire && !rd_in_range;
    out_attr_d  = '0;
    out_frame_d = '0;
    if (rd_fire && rd_in_range) begin
      out_attr_d  = rd_attr;
      out_frame_d = rd_frame;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q  <= 1'b0;
      rd_err_q    <= 1'b0;
      out_attr_q  <= '0;
      out_frame_q <= '0;
    end else begin
      rd_valid_q  <= rd_valid_d;
      rd_err_q    <= rd_err_d;
      out_attr_q  <= out_attr_d;
      out_frame_q <= out_frame_d;
    end
  end

  assign rd_valid       = rd_valid_q;
  assign rd_err         = rd_err_q;
  assign out_width      = out_attr_q.width;
  assign out_height     = out_attr_q.height;
  assign out_anim_steps = out_attr_q.anim_steps;
  assign out_anim_frame = out_frame_q;

endmodule

// File: tb/tb_sprite_attr_bank.sv
// Bench for sprite_attr_bank: directed vector table, a hand-written
// out-of-range sequence on a 6-slot bank, and randomized traffic vs a model.
module tb_sprite_attr_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, wr_en, rd_req, oe, frame_tick;
  logic [2:0] wr_idx, rd_idx, wr_anim_steps;
  logic [5:0] wr_width, wr_height;

  logic       v8, e8, v6, e6;
  logic [5:0] w8, h8, w6, h6;
  logic [2:0] s8, f8, s6, f6;

  sprite_attr_bank #(
    .NUM_SPRITES(8), .DIM_W(6), .ANIM_W(3), .IDX_W(3)
  ) dut8 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_idx(wr_idx), .wr_width(wr_width),
    .wr_height(wr_height), .wr_anim_steps(wr_anim_steps), .rd_req(rd_req), .rd_idx(rd_idx),
    .oe(oe), .frame_tick(frame_tick), .rd_valid(v8), .rd_err(e8), .out_width(w8),
    .out_height(h8), .out_anim_steps(s8), .out_anim_frame(f8)
  );

  sprite_attr_bank #(
    .NUM_SPRITES(6), .DIM_W(6), .ANIM_W(3), .IDX_W(3)
  ) dut6 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_idx(wr_idx), .wr_width(wr_width),
    .wr_height(wr_height), .wr_anim_steps(wr_anim_steps), .rd_req(rd_req), .rd_idx(rd_idx),
    .oe(oe), .frame_tick(frame_tick), .rd_valid(v6), .rd_err(e6), .out_width(w6),
    .out_height(h6), .out_anim_steps(s6), .out_anim_frame(f6)
  );

  typedef struct {
    logic       rst, wen;
    logic [2:0] widx;
    logic [5:0] ww, wh;
    logic [2:0] ws;
    logic       rreq;
    logic [2:0] ridx;
    logic       oe, tick;
    logic [19:0] exp;  // {valid, err, width, height, steps, frame}
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Model state per bank: [0] = 8 slots, [1] = 6 slots.
  int nums [2] = '{8, 6};
  int mw [2][8];
  int mh [2][8];
  int ms [2][8];
  int mf [2][8];

  function automatic vec_t mk(int rst, int wen, int widx, int ww, int wh, int ws, int rreq,
                              int ridx, int o, int tick, int ev, int ee, int ew, int eh,
                              int es, int ef);
    vec_t r;
    r.rst = rst[0]; r.wen = wen[0]; r.widx = widx[2:0]; r.ww = ww[5:0]; r.wh = wh[5:0];
    r.ws = ws[2:0]; r.rreq = rreq[0]; r.ridx = ridx[2:0]; r.oe = o[0]; r.tick = tick[0];
    r.exp = {ev[0], ee[0], ew[5:0], eh[5:0], es[2:0], ef[2:0]};
    return r;
  endfunction

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got v=%b e=%b w=%0d h=%0d s=%0d f=%0d, want v=%b e=%b w=%0d h=%0d s=%0d f=%0d",
               name, act[19], act[18], act[17:12], act[11:6], act[5:3], act[2:0],
               exp[19], exp[18], exp[17:12], exp[11:6], exp[5:3], exp[2:0]);
    end
  endtask

  // Applies one cycle of inputs, advances the model, checks both banks.
  task automatic step(input vec_t v, output logic [19:0] got8, output logic [19:0] got6);
    logic [19:0] exp [2];
    reset = v.rst; wr_en = v.wen; wr_idx = v.widx; wr_width = v.ww; wr_height = v.wh;
    wr_anim_steps = v.ws; rd_req = v.rreq; rd_idx = v.ridx; oe = v.oe; frame_tick = v.tick;
    for (int d = 0; d < 2; d++) begin
      int n = nums[d];
      int r = int'(v.ridx);
      int wi = int'(v.widx);
      bit whit = v.wen && (wi < n);
      if (v.rst || !(v.rreq && v.oe)) exp[d] = '0;
      else if (r >= n) exp[d] = {2'b11, 18'd0};
      else if (whit && wi == r) exp[d] = {2'b10, v.ww, v.wh, v.ws, 3'd0};
      else exp[d] = {2'b10, 6'(mw[d][r]), 6'(mh[d][r]), 3'(ms[d][r]), 3'(mf[d][r])};
      for (int s = 0; s < n; s++) begin
        if (v.rst) begin
          mw[d][s] = 0; mh[d][s] = 0; ms[d][s] = 0; mf[d][s] = 0;
        end else if (whit && wi == s) begin
          mw[d][s] = int'(v.ww); mh[d][s] = int'(v.wh); ms[d][s] = int'(v.ws); mf[d][s] = 0;
        end else if (v.tick) begin
          mf[d][s] = (ms[d][s] <= 1) ? 0 : (mf[d][s] + 1) % ms[d][s];
        end
      end
    end
    @(posedge clk);
    #1;
    got8 = {v8, e8, w8, h8, s8, f8};
    got6 = {v6, e6, w6, h6, s6, f6};
    check("model8", got8, exp[0]);
    check("model6", got6, exp[1]);
  endtask

  vec_t tbl [22];
  logic [19:0] g8, g6;

  initial begin
    reset = 1'b1; wr_en = 0; wr_idx = 0; wr_width = 0; wr_height = 0; wr_anim_steps = 0;
    rd_req = 0; rd_idx = 0; oe = 0; frame_tick = 0;

    //          rst wen wi ww  wh  ws rq ri oe tk   ev ee ew  eh  es ef
    tbl[0]  = mk(1, 0, 0, 0,  0,  0, 0, 0, 0, 0,   0, 0, 0,  0,  0, 0);
    tbl[1]  = mk(0, 0, 0, 0,  0,  0, 1, 0, 1, 0,   1, 0, 0,  0,  0, 0);
    tbl[2]  = mk(0, 1, 5, 40, 12, 4, 0, 0, 0, 0,   0, 0, 0,  0,  0, 0);
    tbl[3]  = mk(0, 0, 0, 0,  0,  0, 1, 5, 1, 0,   1, 0, 40, 12, 4, 0);
    tbl[4]  = mk(0, 1, 1, 10, 20, 1, 1, 5, 1, 1,   1, 0, 40, 12, 4, 0);
    tbl[5]  = mk(0, 0, 0, 0,  0,  0, 1, 5, 1, 1,   1, 0, 40, 12, 4, 1);
    tbl[6]  = mk(0, 0, 0, 0,  0,  0, 1, 5, 1, 1,   1, 0, 40, 12, 4, 2);
    tbl[7]  = mk(0, 0, 0, 0,  0,  0, 1, 5, 1, 1,   1, 0, 40, 12, 4, 3);
    tbl[8]  = mk(0, 0, 0, 0,  0,  0, 1, 5, 1, 1,   1, 0, 40, 12, 4, 0);
    tbl[9]  = mk(0, 0, 0, 0,  0,  0, 1, 5, 1, 0,   1, 0, 40, 12, 4, 1);
    tbl[10] = mk(0, 0, 0, 0,  0,  0, 1, 1, 1, 0,   1, 0, 10, 20, 1, 0);
    tbl[11] = mk(0, 1, 2, 5,  6,  3, 0, 0, 0, 0,   0, 0, 0,  0,  0, 0);
    tbl[12] = mk(0, 0, 0, 0,  0,  0, 0, 0, 0, 1,   0, 0, 0,  0,  0, 0);
    tbl[13] = mk(0, 0, 0, 0,  0,  0, 0, 0, 0, 1,   0, 0, 0,  0,  0, 0);
    tbl[14] = mk(0, 1, 2, 33, 44, 7, 1, 2, 1, 1,   1, 0, 33, 44, 7, 0);
    tbl[15] = mk(0, 0, 0, 0,  0,  0, 1, 2, 1, 0,   1, 0, 33, 44, 7, 0);
    tbl[16] = mk(0, 0, 0, 0,  0,  0, 1, 5, 1, 0,   1, 0, 40, 12, 4, 0);
    tbl[17] = mk(0, 0, 0, 0,  0,  0, 1, 5, 0, 0,   0, 0, 0,  0,  0, 0);
    tbl[18] = mk(1, 0, 0, 0,  0,  0, 1, 5, 1, 0,   0, 0, 0,  0,  0, 0);
    tbl[19] = mk(0, 0, 0, 0,  0,  0, 1, 5, 1, 0,   1, 0, 0,  0,  0, 0);
    tbl[20] = mk(0, 0, 0, 0,  0,  0, 1, 2, 1, 0,   1, 0, 0,  0,  0, 0);
    tbl[21] = mk(0, 0, 0, 0,  0,  0, 0, 0, 0, 0,   0, 0, 0,  0,  0, 0);

    for (int i = 0; i < 22; i++) begin
      step(tbl[i], g8, g6);
      check($sformatf("vec%0d", i), g8, tbl[i].exp);
    end

    // Six-slot bank: fill slots, then writes to 6 and 7 must not disturb it.
    for (int i = 0; i < 6; i++) step(mk(0, 1, i, 3 * i + 1, 50 - i, i, 0, 0, 0, 0,
                                        0, 0, 0, 0, 0, 0), g8, g6);
    step(mk(0, 1, 6, 63, 63, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), g8, g6);
    step(mk(0, 1, 7, 62, 61, 5, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0), g8, g6);
    check("oor_read_7", g6, {2'b11, 18'd0});
    step(mk(0, 0, 0, 0, 0, 0, 1, 6, 1, 1, 0, 0, 0, 0, 0, 0), g8, g6);
    check("oor_read_6", g6, {2'b11, 18'd0});
    for (int i = 0; i < 6; i++) begin
      logic [5:0] ew, eh;
      logic [2:0] es, ef;
      step(mk(0, 0, 0, 0, 0, 0, 1, i, 1, 0, 0, 0, 0, 0, 0, 0), g8, g6);
      ew = 6'(3 * i + 1); eh = 6'(50 - i); es = 3'(i);
      ef = (i <= 1) ? 3'd0 : 3'(1 % i);  // one tick since each slot was written
      check($sformatf("keep6_slot%0d", i), g6, {2'b10, ew, eh, es, ef});
    end

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      vec_t v;
      v = mk(($urandom_range(0, 59) == 0) ? 1 : 0, ($urandom_range(0, 2) == 0) ? 1 : 0,
             $urandom_range(0, 7), $urandom_range(0, 63), $urandom_range(0, 63),
             $urandom_range(0, 7), ($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 7),
             ($urandom_range(0, 7) != 0) ? 1 : 0, ($urandom_range(0, 2) == 0) ? 1 : 0,
             0, 0, 0, 0, 0, 0);
      step(v, g8, g6);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
